// File: rtl/dco_pulse_gen.sv
// dco_pulse_gen: digitally controlled square-wave generator feeding the phase
// detector. High/low phase lengths come from a double-buffered control word.
// One-shot advance/retard requests stretch or shrink a single low phase.
module dco_pulse_gen #(
  parameter int N_BIT = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             enable,
  input  logic             load,
  input  logic [N_BIT-1:0] high_cnt,
  input  logic [N_BIT-1:0] low_cnt,
  input  logic             shift_valid,
  input  logic             shift_dir,
  input  logic [N_BIT-1:0] shift_amt,
  output logic             f_gen,
  output logic             rise,
  output logic             cfg_ack,
  output logic             shift_ack,
  output logic             shift_pending,
  output logic             active
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  localparam logic [N_BIT-1:0] ONE_N   = N_BIT'(1);
  localparam logic [N_BIT:0]   CNT_ONE = (N_BIT+1)'(1);

  state_t state_q, state_d;

  logic [N_BIT:0]   cnt_q, cnt_d;
  logic [N_BIT-1:0] shd_h_q, shd_h_d, shd_l_q, shd_l_d;
  logic             shd_new_q, shd_new_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [N_BIT-1:0] act_h_q, act_h_d, act_l_q, act_l_d;
  logic [N_BIT:0]   leff_q, leff_d;
  logic             pend_q, pend_d, pdir_q, pdir_d;
  logic [N_BIT-1:0] pamt_q, pamt_d;
  logic             f_gen_q, f_gen_d, rise_q, rise_d;
  logic             cfg_ack_q, cfg_ack_d, shift_ack_q, shift_ack_d;

  logic             high_done, low_done, start;
  logic [N_BIT:0]   l_base, amt_ext;

  // A zero-length phase would stall the counter; treat 0 as 1.
  function automatic logic [N_BIT-1:0] min1(input logic [N_BIT-1:0] v);
    return (v == '0) ? ONE_N : v;
  endfunction

  // Phase-complete detection; counts run 1..length inclusive.
  assign high_done = (state_q == S_HIGH) && (cnt_q >= {1'b0, act_h_q});
  assign low_done  = (state_q == S_LOW)  && (cnt_q >= leff_q);
  // Any entry into HIGH is a rising transition of f_gen.
  assign start     = (state_d == S_HIGH) && (state_q != S_HIGH);

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: enable only matters in IDLE and at the end of LOW
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable && cfg_valid_q) state_d = S_HIGH;
      S_HIGH: if (high_done)             state_d = S_LOW;
      S_LOW:  if (low_done)              state_d = enable ? S_HIGH : S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // Output, counter, config-transfer and shift bookkeeping
  always_comb begin
    f_gen_d     = (state_d == S_HIGH);
    rise_d      = start;
    cfg_ack_d   = 1'b0;
    shift_ack_d = 1'b0;
    cnt_d       = cnt_q;
    shd_h_d     = shd_h_q;
    shd_l_d     = shd_l_q;
    shd_new_d   = shd_new_q;
    cfg_valid_d = cfg_valid_q;
    act_h_d     = act_h_q;
    act_l_d     = act_l_q;
    leff_d      = leff_q;
    pend_d      = pend_q;
    pdir_d      = pdir_q;
    pamt_d      = pamt_q;
    l_base      = {1'b0, act_l_q};
    amt_ext     = {1'b0, pamt_q};

    if (start || high_done)   cnt_d = CNT_ONE;
    else if (state_d == S_IDLE) cnt_d = '0;
    else                      cnt_d = cnt_q + CNT_ONE;

    // Config only changes at a rising edge; a coincident load wins over shadow.
    if (start) begin
      if (load) begin
        act_h_d   = min1(high_cnt);
        act_l_d   = min1(low_cnt);
        cfg_ack_d = 1'b1;
      end else if (shd_new_q) begin
        act_h_d   = min1(shd_h_q);
        act_l_d   = min1(shd_l_q);
        cfg_ack_d = 1'b1;
      end
      shd_new_d = 1'b0;
    end
    if (load) begin
      shd_h_d     = high_cnt;
      shd_l_d     = low_cnt;
      cfg_valid_d = 1'b1;
      if (!start) shd_new_d = 1'b1;
    end

    // Low length for the coming LOW phase, with any pending shift folded in.
    if (high_done) begin
      leff_d = l_base;
      if (pend_q) begin
        if (pdir_q)                leff_d = l_base + amt_ext;
        else if (amt_ext >= l_base) leff_d = CNT_ONE;
        else                       leff_d = l_base - amt_ext;
        shift_ack_d = 1'b1;
        pend_d      = 1'b0;
      end
    end
    // New requests are only taken when nothing is pending at this edge.
    if (shift_valid && !pend_q) begin
      pend_d = 1'b1;
      pdir_d = shift_dir;
      pamt_d = shift_amt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt_q       <= '0;
      shd_h_q     <= '0;
      shd_l_q     <= '0;
      shd_new_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      act_h_q     <= '0;
      act_l_q     <= '0;
      leff_q      <= '0;
      pend_q      <= 1'b0;
      pdir_q      <= 1'b0;
      pamt_q      <= '0;
      f_gen_q     <= 1'b0;
      rise_q      <= 1'b0;
      cfg_ack_q   <= 1'b0;
      shift_ack_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shd_h_q     <= shd_h_d;
      shd_l_q     <= shd_l_d;
      shd_new_q   <= shd_new_d;
      cfg_valid_q <= cfg_valid_d;
      act_h_q     <= act_h_d;
      act_l_q     <= act_l_d;
      leff_q      <= leff_d;
      pend_q      <= pend_d;
      pdir_q      <= pdir_d;
      pamt_q      <= pamt_d;
      f_gen_q     <= f_gen_d;
      rise_q      <= rise_d;
      cfg_ack_q   <= cfg_ack_d;
      shift_ack_q <= shift_ack_d;
    end
  end

  assign f_gen         = f_gen_q;
  assign rise          = rise_q;
  assign cfg_ack       = cfg_ack_q;
  assign shift_ack     = shift_ack_q;
  assign shift_pending = pend_q;
  assign active        = (state_q != S_IDLE);

endmodule

// File: doc/dco_pulse_gen.md
Name: dco_pulse_gen

Overview:
- Digitally controlled pulse generator: the generating end of the phase-measurement path.
- Produces the periodic square wave f_gen. Its high and low phase lengths, in Clock cycles, are set by a control word.
- Supports one-shot phase advance/retard requests from the loop filter.
- f_gen is the feedback signal compared against the reference by the phase/frequency detector. It is registered and glitch-free.

Parameters:
N_BIT, 8, width of phase-length and shift-amount fields (matches the detector's measurement width)

Ports:
Clock  input  1  system clock
nReset  input  1  asynchronous, active-low reset
enable  input  1  run request; level-sensitive
load  input  1  1-cycle strobe; capture high_cnt/low_cnt into shadow
high_cnt  input  N_BIT  requested high-phase length in cycles
low_cnt  input  N_BIT  requested low-phase length in cycles
shift_valid  input  1  1-cycle strobe; request phase shift
shift_dir  input  1  0 = advance (shorten low phase), 1 = retard (lengthen low phase)
shift_amt  input  N_BIT  shift magnitude in cycles
f_gen  output  1  generated square wave (registered)
rise  output  1  1-cycle pulse coincident with the first high cycle of f_gen
cfg_ack  output  1  1-cycle pulse when shadow config becomes active
shift_ack  output  1  1-cycle pulse when a pending shift is applied
shift_pending  output  1  a shift request is accepted and not yet applied
active  output  1  state != IDLE

Behaviour:
- Reset (async, nReset=0): state IDLE; f_gen, rise, cfg_ack, shift_ack, shift_pending, active = 0; shadow/active config = 0; cfg_valid = 0; counter = 0.
- Config:
  - load=1 captures high_cnt/low_cnt into shadow and sets cfg_valid=1 (sticky until reset).
  - Shadow is copied to the active config H/L only at a rising transition of f_gen, including start from IDLE; cfg_ack pulses in that same cycle.
  - A load on the same edge as a transfer bypasses the shadow: the new inputs become active and cfg_ack pulses.
  - Without a new load since the last transfer, there is no transfer and no cfg_ack.
  - Value 0 is treated as 1 for both H and L.
- States IDLE, HIGH, LOW. Counter is N_BIT+1 bits wide.
  - IDLE:
    - At an edge with enable=1 and cfg_valid=1: go to HIGH, f_gen<=1, rise<=1, counter<=1.
    - Otherwise f_gen stays 0. Latency from enable sampled high to f_gen=1 is 1 cycle.
  - HIGH:
    - While counter<H: counter+1.
    - At counter==H: go to LOW, f_gen<=0, counter<=1, latch Leff.
    - f_gen is therefore high for exactly H cycles.
  - LOW:
    - While counter<Leff: counter+1.
    - At counter==Leff: if enable=1, go to HIGH (f_gen<=1, rise<=1, counter<=1, config transfer); else go to IDLE with f_gen=0.
- Period is H+Leff cycles. enable is sampled only in IDLE and at the end of LOW, so a period is never truncated.
- Shift:
  - shift_valid while shift_pending=0: store dir/amt, shift_pending<=1.
  - shift_valid while shift_pending=1: dropped, with no ack.
  - Applied on the HIGH->LOW transition, where Leff is computed:
    - retard: Leff = L + amt (N_BIT+1 bits, no overflow).
    - advance: Leff = L - amt, clamped to a minimum of 1.
  - On apply: shift_ack pulses and shift_pending clears in the same cycle.
  - With no pending shift, Leff = L.
  - A shift request arriving on the transition edge itself is not applied until the next period.
- Shift requests are accepted in IDLE and remain pending across IDLE.
- rise, cfg_ack and shift_ack are never high for 2 consecutive cycles.
- Reset mid-operation: all outputs 0 immediately; cfg_valid cleared, so a new load is required before enable takes effect.

Test Plan:
- load H=3,L=5; enable=1 -> f_gen 3 cycles high / 5 cycles low repeating; rise every 8 cycles; cfg_ack only with the first rise; active=1.
- Running 3/5, load H=2,L=2 during HIGH -> current period completes as 3/5; next period 2/2 with cfg_ack on its rise; no further cfg_ack.
- Running 3/5, shift retard amt=4 -> exactly one low phase of 9 cycles then back to 5; shift_ack once at HIGH->LOW. A second shift_valid while pending is dropped (only one ack).
- Running 3/5, shift advance amt=10 -> one low phase of 1 cycle (clamp), then 5. Config H=0,L=0 -> period 2 (1 high / 1 low).
- Drop enable mid-HIGH -> HIGH and LOW complete, then IDLE with f_gen=0, active=0. Re-raise enable -> f_gen=1 one cycle later with rise.
- Assert nReset mid-HIGH -> f_gen=0 asynchronously. After release, enable=1 without load -> stays IDLE (f_gen=0). Then load H=4,L=4 -> running with cfg_ack on first rise.
